// File: rtl/fetch_pkg.sv
// Shared constants and types for the instruction fetch stage.
// The stop-opcode helper is only used when FETCH_HALT_EN is defined.
package fetch_pkg;

  localparam int unsigned ADDR_W = 4;
  localparam int unsigned INST_W = 16;
  localparam int unsigned OPC_HI = 15;
  localparam int unsigned OPC_LO = 12;
  localparam logic [OPC_HI-OPC_LO:0] OPC_HALT = 4'b0000;

  typedef enum logic {
    ST_RUN,
    ST_HALTED
  } fetch_state_e;

  function automatic logic is_halt_op(input logic [INST_W-1:0] inst);
    return inst[OPC_HI:OPC_LO] == OPC_HALT;
  endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// Bundle of the ROM, redirect and decode-handshake signals around the fetch stage.
// master: the fetch stage itself; slave: ROM/execute/decode side.
interface instruction_fetch_if #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned INST_W = 16
);

  logic [ADDR_W-1:0] rom_addr;
  logic [INST_W-1:0] rom_inst;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              if_valid;
  logic              if_ready;
  logic [INST_W-1:0] if_inst;
  logic [ADDR_W-1:0] if_pc;
  logic              halted;

  modport master (
    output rom_addr,
    input  rom_inst,
    input  redirect_valid,
    input  redirect_pc,
    output if_valid,
    input  if_ready,
    output if_inst,
    output if_pc,
    output halted
  );

  modport slave (
    input  rom_addr,
    output rom_inst,
    output redirect_valid,
    output redirect_pc,
    input  if_valid,
    output if_ready,
    input  if_inst,
    input  if_pc,
    input  halted
  );

endinterface

// File: rtl/pc_counter.sv
// Program counter: async reset to RESET_PC, redirect load has priority over increment.
// Increment wraps naturally at 2**ADDR_W.
module pc_counter #(
  parameter int unsigned     ADDR_W   = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect_i,
  input  logic [ADDR_W-1:0] redirect_pc_i,
  input  logic              inc_i,
  output logic [ADDR_W-1:0] pc_o
);

  logic [ADDR_W-1:0] pc_q, pc_d;

  always_comb begin
    pc_d = pc_q;
    if (redirect_i) begin
      pc_d = redirect_pc_i;
    end else if (inc_i) begin
      pc_d = pc_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: drives ROM address from pc, registers the returned word and presents it to
// decode over valid/ready. Define FETCH_HALT_EN to stop fetching on opcode 4'b0000.
module instruction_fetch #(
  parameter int unsigned       ADDR_W   = fetch_pkg::ADDR_W,
  parameter int unsigned       INST_W   = fetch_pkg::INST_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input logic                 clk,
  input logic                 rst,
  instruction_fetch_if.master bus
);

  import fetch_pkg::*;

  logic [ADDR_W-1:0] pc;
  logic              load;
  logic              inc;
  logic              run;
  logic              halt_hit;

  logic              valid_q, valid_d;
  logic [INST_W-1:0] inst_q, inst_d;
  logic [ADDR_W-1:0] if_pc_q, if_pc_d;

  pc_counter #(
    .ADDR_W  (ADDR_W),
    .RESET_PC(RESET_PC)
  ) u_pc_counter (
    .clk          (clk),
    .rst          (rst),
    .redirect_i   (bus.redirect_valid),
    .redirect_pc_i(bus.redirect_pc),
    .inc_i        (inc),
    .pc_o         (pc)
  );

  assign load = !valid_q || bus.if_ready;

`ifdef FETCH_HALT_EN
  fetch_state_e state_q, state_d;

  assign run      = (state_q == ST_RUN);
  assign halt_hit = is_halt_op(bus.rom_inst);

  always_comb begin
    state_d = state_q;
    if (bus.redirect_valid) begin
      state_d = ST_RUN;
    end else if (run && load && halt_hit) begin
      state_d = ST_HALTED;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  assign bus.halted = (state_q == ST_HALTED);
`else
  assign run        = 1'b1;
  assign halt_hit   = 1'b0;
  assign bus.halted = 1'b0;
`endif

  // Redirect flushes the held word even when decode is accepting it this cycle.
  always_comb begin
    valid_d = valid_q;
    inst_d  = inst_q;
    if_pc_d = if_pc_q;
    inc     = 1'b0;
    if (bus.redirect_valid) begin
      valid_d = 1'b0;
    end else if (run && load) begin
      valid_d = 1'b1;
      inst_d  = bus.rom_inst;
      if_pc_d = pc;
      inc     = !halt_hit;
    end else if (valid_q && bus.if_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      inst_q  <= '0;
      if_pc_q <= '0;
    end else begin
      valid_q <= valid_d;
      inst_q  <= inst_d;
      if_pc_q <= if_pc_d;
    end
  end

  assign bus.rom_addr = pc;
  assign bus.if_valid = valid_q;
  assign bus.if_inst  = inst_q;
  assign bus.if_pc    = if_pc_q;

endmodule
